median_column_feeder: RTL and testbench

Raster-to-column line buffer for the 3x3 median filter datapath. Accepts one 8-bit pixel per valid cycle in raster order. Holds the two previous image lines and emits a vertically aligned 3-pixel column (rows y-2, y-1, y at column x) each valid cycle. The column feeds the three-input sorting stage directly: top→A, mid→B, bot→C.

---
 rtl/median_column_feeder.sv | 138 +++++++++++++
 tb/tb_median_column_feeder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/median_column_feeder.sv
// median_column_feeder
// Raster-to-column line buffer for the 3x3 median filter. It accepts one
// pixel per valid cycle in raster order and keeps the two previous lines.
// For every accepted pixel it emits the vertically aligned column
// (y-2, y-1, y) at the same x, one cycle later.
//
// Optional build macro: BORDER_REPLICATE_EN
//   defined   : rows 0 and 1 also produce columns, with the missing rows
//               replicated from the nearest available row.
//   undefined : columns are produced only once two lines are primed.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   sof        start of frame (the pixel with it is x=0, y=0)
//   pix_in     8-bit input pixel
//   pix_valid  pix_in valid this cycle (no backpressure)
//   col_top    pixel at (x, y-2), registered
//   col_mid    pixel at (x, y-1), registered
//   col_bot    pixel at (x, y),   registered
//   col_valid  one-cycle pulse per emitted column
//   col_last   emitted column is the last of its line
module median_column_feeder #(
  parameter int IMG_WIDTH = 640,
  parameter int XW        = $clog2(IMG_WIDTH)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sof,
  input  logic [7:0] pix_in,
  input  logic       pix_valid,
  output logic [7:0] col_top,
  output logic [7:0] col_mid,
  output logic [7:0] col_bot,
  output logic       col_valid,
  output logic       col_last
);

  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);

  // line0 holds row y-1, line1 holds row y-2; contents are not reset.
  logic [7:0] line0 [IMG_WIDTH];
  logic [7:0] line1 [IMG_WIDTH];

  logic [XW-1:0] x;
  logic [1:0]    y;

  logic [XW-1:0] x_use;
  logic [1:0]    y_use;
  logic [XW-1:0] x_nxt;
  logic [1:0]    y_nxt;
  logic          x_wrap;
  logic [7:0]    rd0;
  logic [7:0]    rd1;
  logic [7:0]    top_d;
  logic [7:0]    mid_d;
  logic          emit;

  // sof forces the counters before they address the memories, so the
  // pixel carrying sof is written and read at column 0 of row 0.
  always_comb begin
    x_use  = sof ? '0 : x;
    y_use  = sof ? '0 : y;
    x_wrap = (x_use == X_LAST);
    x_nxt  = x_wrap ? '0 : x_use + 1'b1;
    y_nxt  = (x_wrap && (y_use != 2'd2)) ? y_use + 2'd1 : y_use;
    rd0    = line0[x_use];
    rd1    = line1[x_use];
  end

`ifdef BORDER_REPLICATE_EN
  always_comb begin
    top_d = rd1;
    mid_d = rd0;
    emit  = 1'b1;
    case (y_use)
      2'd0: begin
        top_d = pix_in;
        mid_d = pix_in;
      end
      2'd1: begin
        top_d = rd0;
        mid_d = rd0;
      end
      default: ;
    endcase
  end
`else
  always_comb begin
    top_d = rd1;
    mid_d = rd0;
    emit  = (y_use == 2'd2);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (pix_valid) begin
      x <= x_nxt;
      y <= y_nxt;
    end else if (sof) begin
      x <= '0;
      y <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_top   <= '0;
      col_mid   <= '0;
      col_bot   <= '0;
      col_valid <= 1'b0;
      col_last  <= 1'b0;
    end else if (pix_valid) begin
      col_top   <= top_d;
      col_mid   <= mid_d;
      col_bot   <= pix_in;
      col_valid <= emit;
      // Gated by emit so col_last only ever pulses alongside col_valid.
      col_last  <= emit && x_wrap;
    end else begin
      col_valid <= 1'b0;
      col_last  <= 1'b0;
    end
  end

  // Reads above see the pre-write contents; the shift line0 -> line1
  // happens at the same column on the same edge.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      line1[x_use] <= rd0;
      line0[x_use] <= pix_in;
    end
  end

endmodule

// File: tb/tb_median_column_feeder.sv
// Self-checking bench for median_column_feeder with IMG_WIDTH=4.
// Runs the border-replicate scenario when BORDER_REPLICATE_EN is defined,
// otherwise the priming, gap, mid-frame sof, async reset and multi-frame
// scenarios.
module tb_median_column_feeder;

  localparam int W = 4;

  logic       clk;
  logic       rst_n;
  logic       sof;
  logic [7:0] pix_in;
  logic       pix_valid;
  logic [7:0] col_top;
  logic [7:0] col_mid;
  logic [7:0] col_bot;
  logic       col_valid;
  logic       col_last;

  int checks = 0;
  int errors = 0;

  median_column_feeder #(
    .IMG_WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sof      (sof),
    .pix_in   (pix_in),
    .pix_valid(pix_valid),
    .col_top  (col_top),
    .col_mid  (col_mid),
    .col_bot  (col_bot),
    .col_valid(col_valid),
    .col_last (col_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, let the edge take them, sample 1 time unit later.
  task automatic step(input logic s, input logic v, input logic [7:0] p);
    sof       = s;
    pix_valid = v;
    pix_in    = p;
    @(posedge clk);
    #1;
    sof       = 1'b0;
    pix_valid = 1'b0;
    pix_in    = 8'd0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    sof = 1'b0; pix_valid = 1'b0; pix_in = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({col_top, col_mid, col_bot} !== 24'd0) begin
      errors++;
      $display("FAIL reset_data: got %h expected %h", {col_top, col_mid, col_bot}, 24'd0);
    end
    checks++;
    if ({col_valid, col_last} !== 2'b00) begin
      errors++;
      $display("FAIL reset_flags: got %b expected %b", {col_valid, col_last}, 2'b00);
    end
    rst_n = 1'b1;
    step(1'b0, 1'b0, 8'd0);
  endtask

  // Pixels 1..12 from sof; expected columns (i-8, i-4, i) for i >= 9.
  task automatic test_fill(input string tag);
    logic [23:0] exp_col;
    for (int i = 1; i <= 12; i++) begin
      step(i == 1, 1'b1, 8'(i));
      checks++;
      if (col_valid !== (i >= 9)) begin
        errors++;
        $display("FAIL %s_valid[%0d]: got %b expected %b", tag, i, col_valid, (i >= 9));
      end
      checks++;
      if (col_last !== (i == 12)) begin
        errors++;
        $display("FAIL %s_last[%0d]: got %b expected %b", tag, i, col_last, (i == 12));
      end
      if (i >= 9) begin
        exp_col = {8'(i - 8), 8'(i - 4), 8'(i)};
        checks++;
        if ({col_top, col_mid, col_bot} !== exp_col) begin
          errors++;
          $display("FAIL %s_col[%0d]: got %h expected %h", tag, i, {col_top, col_mid, col_bot}, exp_col);
        end
      end
    end
    step(1'b0, 1'b0, 8'd0);
    checks++;
    if (col_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_valid: got %b expected 0", tag, col_valid);
    end
  endtask

  task automatic test_gaps;
    logic [23:0] exp_col;
    for (int i = 1; i <= 12; i++) begin
      step(i == 1, 1'b1, 8'(i));
      checks++;
      if (col_valid !== (i >= 9)) begin
        errors++;
        $display("FAIL gaps_valid[%0d]: got %b expected %b", i, col_valid, (i >= 9));
      end
      exp_col = {8'(i - 8), 8'(i - 4), 8'(i)};
      if (i >= 9) begin
        checks++;
        if ({col_top, col_mid, col_bot} !== exp_col || col_last !== (i == 12)) begin
          errors++;
          $display("FAIL gaps_col[%0d]: got %h/%b expected %h/%b", i,
                   {col_top, col_mid, col_bot}, col_last, exp_col, (i == 12));
        end
      end
      step(1'b0, 1'b0, 8'hEE);
      checks++;
      if (col_valid !== 1'b0 || col_last !== 1'b0) begin
        errors++;
        $display("FAIL gaps_idle[%0d]: got %b%b expected 00", i, col_valid, col_last);
      end
      checks++;
      if (col_bot !== 8'(i)) begin
        errors++;
        $display("FAIL gaps_hold[%0d]: got %0d expected %0d", i, col_bot, i);
      end
    end
  endtask

  task automatic test_midframe_sof;
    logic [23:0] exp_col;
    int nvalid;
    for (int i = 1; i <= 10; i++) step(i == 1, 1'b1, 8'(i));
    nvalid = 0;
    for (int k = 1; k <= 12; k++) begin
      step(k == 1, 1'b1, 8'(20 + k));
      checks++;
      if (col_valid !== (k >= 9)) begin
        errors++;
        $display("FAIL midsof_valid[%0d]: got %b expected %b", 20 + k, col_valid, (k >= 9));
      end
      if (col_valid === 1'b1) nvalid++;
      if (k == 9) begin
        exp_col = {8'd21, 8'd25, 8'd29};
        checks++;
        if ({col_top, col_mid, col_bot} !== exp_col) begin
          errors++;
          $display("FAIL midsof_first_col: got %h expected %h", {col_top, col_mid, col_bot}, exp_col);
        end
      end
    end
    checks++;
    if (nvalid != 4) begin
      errors++;
      $display("FAIL midsof_count: got %0d expected 4", nvalid);
    end
  endtask

  task automatic test_async_reset;
    for (int i = 1; i <= 10; i++) step(i == 1, 1'b1, 8'(i));
    // Pixel 10 produced column (2,6,10); reset lands between edges.
    checks++;
    if ({col_valid, col_top, col_mid, col_bot} !== {1'b1, 8'd2, 8'd6, 8'd10}) begin
      errors++;
      $display("FAIL areset_pre: got %b %h expected 1 02060a", col_valid, {col_top, col_mid, col_bot});
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({col_valid, col_last, col_top, col_mid, col_bot} !== 26'd0) begin
      errors++;
      $display("FAIL areset_immediate: got %b%b %h expected 00 000000",
               col_valid, col_last, {col_top, col_mid, col_bot});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 1'b0, 8'd0);
    test_fill("after_reset");
  endtask

  task automatic test_frames;
    int nvalid;
    int nlast;
    int v;
    logic [23:0] exp_col;
    for (int f = 0; f < 3; f++) begin
      nvalid = 0;
      nlast  = 0;
      for (int i = 1; i <= 16; i++) begin
        v = f * 40 + i;
        step(i == 1, 1'b1, 8'(v));
        if (col_valid === 1'b1) begin
          nvalid++;
          exp_col = {8'(v - 8), 8'(v - 4), 8'(v)};
          checks++;
          if ({col_top, col_mid, col_bot} !== exp_col) begin
            errors++;
            $display("FAIL frames_col[%0d,%0d]: got %h expected %h", f, i, {col_top, col_mid, col_bot}, exp_col);
          end
        end
        if (col_last === 1'b1) nlast++;
      end
      checks++;
      if (nvalid != 8 || nlast != 2) begin
        errors++;
        $display("FAIL frames_count[%0d]: got %0d valid %0d last expected 8 valid 2 last", f, nvalid, nlast);
      end
    end
  endtask

  task automatic test_border_replicate;
    logic [23:0] exp_col;
    for (int i = 1; i <= 8; i++) begin
      step(i == 1, 1'b1, 8'(i));
      exp_col = (i <= 4) ? {8'(i), 8'(i), 8'(i)} : {8'(i - 4), 8'(i - 4), 8'(i)};
      checks++;
      if (col_valid !== 1'b1 || col_last !== (i == 4 || i == 8)) begin
        errors++;
        $display("FAIL border_flags[%0d]: got %b%b expected 1%b", i, col_valid, col_last, (i == 4 || i == 8));
      end
      checks++;
      if ({col_top, col_mid, col_bot} !== exp_col) begin
        errors++;
        $display("FAIL border_col[%0d]: got %h expected %h", i, {col_top, col_mid, col_bot}, exp_col);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    sof = 1'b0; pix_valid = 1'b0; pix_in = 8'd0;
    test_reset;
`ifdef BORDER_REPLICATE_EN
    test_border_replicate;
`else
    test_fill("fill");
    test_gaps;
    test_midframe_sof;
    test_async_reset;
    test_frames;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
